// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyph table
// for hex digits (segment order {a,b,c,d,e,f,g}) and the all-off pattern.
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      return SEG_LUT[v];
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot timing: prescaler, scan index and post-advance dead-time counter.
module seg_slot_timer #(
   parameter int NUM_DIGITS  = 8,
   parameter int CLK_DIV     = 5000,
   parameter int DEAD_CYCLES = 2,
   localparam int AW         = $clog2(NUM_DIGITS)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] idx,
   output logic          dead,
   output logic          slot_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int DW = $clog2(DEAD_CYCLES + 2);

   logic [CW-1:0] cnt;
   logic [DW-1:0] dead_cnt;

   assign slot_tick = (cnt == CW'(CLK_DIV - 1));
   assign dead      = (dead_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         dead_cnt <= '0;
      end else begin
         cnt <= slot_tick ? '0 : cnt + 1'b1;
         if (slot_tick) begin
            idx      <= (idx == AW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            dead_cnt <= DW'(DEAD_CYCLES);
         end else if (dead) begin
            dead_cnt <= dead_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment controller: per-digit storage, slot timer and a
// registered output stage driving one-hot anodes and active-low segments.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int CLK_DIV     = 5000,
   parameter int DEAD_CYCLES = 2,
   localparam int AW         = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [3:0]            wr_data,
   input  logic                  wr_dp,
   input  logic                  clr,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic                  slot_tick
);

   logic [NUM_DIGITS-1:0][3:0] val;
   logic [NUM_DIGITS-1:0]      dp;
   logic [NUM_DIGITS-1:0]      valid;
   logic [AW-1:0]              idx;
   logic                       dead;
   logic                       addr_ok;
   logic                       show;

   seg_slot_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .CLK_DIV     (CLK_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .dead      (dead),
      .slot_tick (slot_tick)
   );

   assign addr_ok = (int'(wr_addr) < NUM_DIGITS);

   // The tick cycle is blanked as well, so the registered anode is dark for
   // DEAD_CYCLES+1 cycles after every advance and never shows a stale digit.
   assign show = valid[idx] && !dead && !slot_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val   <= '0;
         dp    <= '0;
         valid <= '0;
      end else if (clr) begin
         dp    <= '0;
         valid <= '0;
      end else if (wr_en && addr_ok) begin
         val[wr_addr]   <= wr_data;
         dp[wr_addr]    <= wr_dp;
         valid[wr_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode <= '0;
         seg   <= SEG_OFF;
         dp_n  <= 1'b1;
      end else if (show) begin
         anode <= NUM_DIGITS'(1) << idx;
         seg   <= seg_of(val[idx]);
         dp_n  <= ~dp[idx];
      end else begin
         anode <= '0;
         seg   <= SEG_OFF;
         dp_n  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: 8-digit and 10-digit instances,
// CLK_DIV=8, DEAD_CYCLES=1; expectations are queued per cycle and popped.
module tb_seg_scan_display;

   typedef struct {
      int          c;
      logic [15:0] anode;
      logic [6:0]  seg;
      logic        dpn;
      logic        tick;
   } exp_t;

   localparam logic [6:0] GLY [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
   localparam logic [6:0] OFF = 7'b1111111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       wr_en1 = 0, wr_dp1 = 0, clr1 = 0;
   logic [2:0] wr_addr1 = '0;
   logic [3:0] wr_data1 = '0;
   logic [7:0] anode1;
   logic [6:0] seg1;
   logic       dpn1, tick1;

   logic       wr_en2 = 0, wr_dp2 = 0, clr2 = 0;
   logic [3:0] wr_addr2 = '0;
   logic [3:0] wr_data2 = '0;
   logic [9:0] anode2;
   logic [6:0] seg2;
   logic       dpn2, tick2;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q1[$];
   exp_t q2[$];

   seg_scan_display #(.NUM_DIGITS(8), .CLK_DIV(8), .DEAD_CYCLES(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .wr_dp(wr_dp1), .clr(clr1),
      .anode(anode1), .seg(seg1), .dp_n(dpn1), .slot_tick(tick1)
   );

   seg_scan_display #(.NUM_DIGITS(10), .CLK_DIV(8), .DEAD_CYCLES(1)) dut10 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2),
      .wr_data(wr_data2), .wr_dp(wr_dp2), .clr(clr2),
      .anode(anode2), .seg(seg2), .dp_n(dpn2), .slot_tick(tick2)
   );

   always #5 clk = ~clk;

   // Edges since reset release; cnt inside the DUT equals cyc % 8.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic cmp(input string nm, input exp_t e, input logic [15:0] a,
                      input logic [6:0] s, input logic d, input logic t);
      checks++;
      if (a !== e.anode || s !== e.seg || d !== e.dpn || t !== e.tick) begin
         failures++;
         $display("FAIL %s cyc=%0d got anode=%h seg=%b dp_n=%b tick=%b want anode=%h seg=%b dp_n=%b tick=%b",
                  nm, e.c, a, s, d, t, e.anode, e.seg, e.dpn, e.tick);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q1.size() > 0 && q1[0].c == cyc) begin
         e = q1.pop_front();
         cmp("nd8", e, 16'(anode1), seg1, dpn1, tick1);
      end
      while (q2.size() > 0 && q2[0].c == cyc) begin
         e = q2.pop_front();
         cmp("nd10", e, 16'(anode2), seg2, dpn2, tick2);
      end
   end

   function automatic exp_t mk(input int c, input logic [15:0] a,
                               input logic [6:0] s, input logic d);
      exp_t e;
      e.c = c; e.anode = a; e.seg = s; e.dpn = d;
      e.tick = (c % 8 == 7);
      return e;
   endfunction

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr1(input logic [2:0] a, input logic [3:0] v,
                      input logic p, input logic c);
      wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = v; wr_dp1 = p; clr1 = c;
      @(posedge clk);
      #1;
      wr_en1 = 1'b0; clr1 = 1'b0; wr_dp1 = 1'b0;
   endtask

   task automatic wr2(input logic [3:0] a, input logic [3:0] v, input logic p);
      wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = v; wr_dp2 = p;
      @(posedge clk);
      #1;
      wr_en2 = 1'b0; wr_dp2 = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog cyc=%0d time limit expired", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d;
      bit sh;

      // Reset state, then three idle scans: blank outputs, tick every 8th cycle.
      for (int c = 0; c <= 24; c++) q1.push_back(mk(c, 16'h0, OFF, 1'b1));
      #32 rst_n = 1'b1;

      wait_cyc(24);
      // Digits 0..7 hold their own index, dp on 3; checked over a full scan.
      for (int c = 41; c <= 104; c++) begin
         s = c - 1; d = (s / 8) % 8;
         sh = (s % 8 != 7) && (s % 8 != 0);
         q1.push_back(mk(c, sh ? 16'(1 << d) : 16'h0, sh ? GLY[d] : OFF,
                         sh ? (d != 3) : 1'b1));
      end
      // Ten-digit unit: only digit 9 written; address 12 is out of range.
      for (int c = 33; c <= 112; c++) begin
         s = c - 1; d = (s / 8) % 10;
         sh = (d == 9) && (s % 8 != 7) && (s % 8 != 0);
         q2.push_back(mk(c, sh ? 16'h200 : 16'h0, sh ? GLY[8] : OFF, !sh));
      end
      for (int k = 0; k < 8; k++) wr1(3'(k), 4'(k), k == 3, 1'b0);
      wr2(4'd9, 4'h8, 1'b1);
      wr2(4'd12, 4'h3, 1'b1);

      // Rewrite digit 5 while it is on screen: A then F, visible 2 edges later.
      wait_cyc(100);
      q1.push_back(mk(106, 16'h20, GLY[10], 1'b1));
      q1.push_back(mk(107, 16'h20, GLY[10], 1'b1));
      for (int c = 108; c <= 111; c++) q1.push_back(mk(c, 16'h20, GLY[15], 1'b1));
      q1.push_back(mk(112, 16'h0, OFF, 1'b1));
      wr1(3'd5, 4'hA, 1'b0, 1'b0);
      wait_cyc(106);
      wr1(3'd5, 4'hF, 1'b0, 1'b0);

      // Clear with a simultaneous write: clear wins, everything blank.
      wait_cyc(120);
      for (int c = 122; c <= 192; c++) q1.push_back(mk(c, 16'h0, OFF, 1'b1));
      wr1(3'd2, 4'h9, 1'b1, 1'b1);

      // Async reset while digit 4 is lit, then restart from idx 0.
      wait_cyc(195);
      q1.push_back(mk(226, 16'h10, GLY[4], 1'b1));
      q1.push_back(mk(227, 16'h10, GLY[4], 1'b1));
      wr1(3'd4, 4'h4, 1'b0, 1'b0);
      wait_cyc(228);
      rst_n = 1'b0;
      q1.push_back(mk(0, 16'h0, OFF, 1'b1));
      for (int c = 1; c <= 10; c++) begin
         sh = (c >= 3) && (c <= 7);
         q1.push_back(mk(c, sh ? 16'h1 : 16'h0, sh ? GLY[14] : OFF, 1'b1));
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(1);
      wr1(3'd0, 4'hE, 1'b0, 1'b0);
      wait_cyc(12);

      checks++;
      if (q1.size() + q2.size() != 0) begin
         failures++;
         $display("FAIL leftover got=%0d want=0 unchecked expectations",
                  q1.size() + q2.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
